iob_timer_ctrl: RTL and testbench

//  Shares one iob_timer instance among N_REQ requesters through a round-robin arbiter.

---
 rtl/iob_timer_ctrl.sv | 140 ++++++++++++++
 tb/tb_iob_timer_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_timer_ctrl.sv
// iob_timer_ctrl
//   Round-robin front end that lets N_REQ requesters share one iob_timer.
//   A granted request runs either a SAMPLE (STOP snapshot, read HIGH, read
//   LOW -> coherent 64-bit tstamp) or a RESET (soft-reset the counter) on the
//   timer's valid/address/wdata/rdata/ready bus.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid[N_REQ]        level request, held until the matching ack bit
//   req_op[N_REQ]           0=SAMPLE, 1=RESET; stable while req_valid=1
//   ack[N_REQ]              one-cycle one-hot completion pulse
//   tstamp[64]              last SAMPLE result, held until the next SAMPLE
//   grant_id[IDW]           requester being served (valid while busy)
//   busy                    a sequence is in progress
//   tmr_valid/address/wdata timer bus request
//   tmr_rdata/tmr_ready     timer bus response
module iob_timer_ctrl #(
   parameter int         N_REQ      = 4,
   parameter logic [1:0] ADDR_RESET = 2'd0,
   parameter logic [1:0] ADDR_STOP  = 2'd1,
   parameter logic [1:0] ADDR_HIGH  = 2'd2,
   parameter logic [1:0] ADDR_LOW   = 2'd3,
   parameter int         IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_valid,
   input  logic [N_REQ-1:0] req_op,
   output logic [N_REQ-1:0] ack,
   output logic [63:0]      tstamp,
   output logic [IDW-1:0]   grant_id,
   output logic             busy,
   output logic             tmr_valid,
   output logic [1:0]       tmr_address,
   output logic [31:0]      tmr_wdata,
   input  logic [31:0]      tmr_rdata,
   input  logic             tmr_ready
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_STOP_I = 4'd1;
   localparam logic [3:0] S_STOP_W = 4'd2;
   localparam logic [3:0] S_HI_I   = 4'd3;
   localparam logic [3:0] S_HI_W   = 4'd4;
   localparam logic [3:0] S_LO_I   = 4'd5;
   localparam logic [3:0] S_LO_W   = 4'd6;
   localparam logic [3:0] S_RST_I  = 4'd7;
   localparam logic [3:0] S_RST_W  = 4'd8;
   localparam logic [3:0] S_DONE   = 4'd9;

   logic [3:0]     r_state;
   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] r_gid;
   logic [63:0]    r_ts;

   logic           w_found;
   logic [IDW-1:0] w_win;
   logic [IDW-1:0] w_nxt;
   int             w_sum;

   // Round-robin search starting at r_ptr. Walking the offsets from highest
   // to lowest lets the smallest offset with a request overwrite the rest.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = 0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         w_sum = int'(r_ptr) + i;
         if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
         if (req_valid[IDW'(w_sum)]) begin
            w_found = 1'b1;
            w_win   = IDW'(w_sum);
         end
      end
   end

   assign w_nxt = (int'(w_win) == N_REQ-1) ? '0 : w_win + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_gid   <= '0;
         r_ts    <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_found) begin
               r_gid   <= w_win;
               r_ptr   <= w_nxt;
               r_state <= req_op[w_win] ? S_RST_I : S_STOP_I;
            end
            S_STOP_I: r_state <= S_STOP_W;
            S_STOP_W: if (tmr_ready) r_state <= S_HI_I;
            S_HI_I:   r_state <= S_HI_W;
            S_HI_W: if (tmr_ready) begin
               r_ts[63:32] <= tmr_rdata;
               r_state     <= S_LO_I;
            end
            S_LO_I:   r_state <= S_LO_W;
            S_LO_W: if (tmr_ready) begin
               r_ts[31:0] <= tmr_rdata;
               r_state    <= S_DONE;
            end
            S_RST_I:  r_state <= S_RST_W;
            S_RST_W: if (tmr_ready) r_state <= S_DONE;
            S_DONE:   r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   // Bus outputs decode straight from state so an async reset drops them in
   // the same cycle. Every *_I state is followed by a *_W state, so tmr_valid
   // can never be high two cycles in a row.
   always_comb begin
      tmr_valid   = 1'b0;
      tmr_address = ADDR_HIGH;
      tmr_wdata   = 32'd0;
      case (r_state)
         S_STOP_I: begin tmr_valid = 1'b1; tmr_address = ADDR_STOP; end
         S_STOP_W: tmr_address = ADDR_STOP;
         S_HI_I:   begin tmr_valid = 1'b1; tmr_address = ADDR_HIGH; end
         S_HI_W:   tmr_address = ADDR_HIGH;
         S_LO_I:   begin tmr_valid = 1'b1; tmr_address = ADDR_LOW; end
         S_LO_W:   tmr_address = ADDR_LOW;
         S_RST_I:  begin tmr_valid = 1'b1; tmr_address = ADDR_RESET; tmr_wdata = 32'd1; end
         S_RST_W:  begin tmr_address = ADDR_RESET; tmr_wdata = 32'd1; end
         default:  ;
      endcase
   end

   always_comb begin
      ack = '0;
      if (r_state == S_DONE) ack[r_gid] = 1'b1;
   end

   assign busy     = (r_state != S_IDLE);
   assign grant_id = r_gid;
   assign tstamp   = r_ts;

endmodule

// File: tb/tb_iob_timer_ctrl.sv
// tb_iob_timer_ctrl
//   Drives iob_timer_ctrl against a small timer model (64-bit counter,
//   snapshot on STOP, ready one cycle after valid plus optional wait) and
//   checks it every cycle against a request-level model, plus directed
//   latency/ordering expectations.
module tb_iob_timer_ctrl;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_op = '0;
   logic [N-1:0]  ack;
   logic [63:0]   tstamp;
   logic [1:0]    grant_id;
   logic          busy;
   logic          tmr_valid;
   logic [1:0]    tmr_address;
   logic [31:0]   tmr_wdata;
   logic [31:0]   tmr_rdata;
   logic          tmr_ready;

   iob_timer_ctrl #(.N_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
      .ack(ack), .tstamp(tstamp), .grant_id(grant_id), .busy(busy),
      .tmr_valid(tmr_valid), .tmr_address(tmr_address), .tmr_wdata(tmr_wdata),
      .tmr_rdata(tmr_rdata), .tmr_ready(tmr_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- timer model ----------------
   logic [63:0] t_cnt = '0;
   logic [63:0] t_snap = '0;
   logic        t_en = 1'b0;
   logic        t_ld = 1'b0;
   logic [63:0] t_ld_val = '0;
   int          t_wait = 0;
   int          t_rdy;

   always @(posedge clk) begin
      if (t_ld) t_cnt <= t_ld_val;
      else if (tmr_valid && tmr_address == 2'd0 && tmr_wdata[0]) t_cnt <= '0;
      else if (t_en) t_cnt <= t_cnt + 64'd1;
      if (tmr_valid && tmr_address == 2'd1) t_snap <= t_cnt;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) t_rdy <= 0;
      else if (tmr_valid) t_rdy <= t_wait + 1;
      else if (t_rdy > 0) t_rdy <= t_rdy - 1;
   end

   assign tmr_ready = (t_rdy == 1);
   assign tmr_rdata = (tmr_address == 2'd2) ? t_snap[63:32] :
                      (tmr_address == 2'd3) ? t_snap[31:0] : 32'd0;

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   // request-level model: a granted op becomes a list of bus steps (register
   // addresses); each step is one issue cycle then a wait for ready; after
   // the list empties there is one ack cycle.
   bit         m_act, m_issue, m_done;
   int         m_gid, m_ptr;
   logic [1:0] m_steps[$];
   logic [63:0] m_ts;
   bit         prev_valid;

   int         ack_id[$];
   int         ack_cyc[$];
   logic [1:0] bus_addr[$];
   logic [31:0] bus_wd[$];

   always @(negedge clk) begin
      logic       e_live;
      logic [1:0] e_addr;
      logic [1:0] s;
      int         k;
      if (!rst_n) begin
         m_act = 0; m_issue = 0; m_done = 0; m_gid = 0; m_ptr = 0;
         m_steps.delete(); m_ts = '0; prev_valid = 0;
      end
      e_live = m_act && !m_done;
      e_addr = e_live ? m_steps[0] : 2'd2;
      chk("busy", busy, m_act);
      chk("tmr_valid", tmr_valid, e_live && m_issue);
      chk("tmr_address", tmr_address, e_addr);
      chk("tmr_wdata", tmr_wdata, (e_live && e_addr == 2'd0) ? 32'd1 : 32'd0);
      chk("ack", ack, m_done ? (4'b0001 << m_gid) : 4'b0000);
      chk("tstamp", tstamp, m_ts);
      if (m_act) chk("grant_id", grant_id, m_gid);
      if (tmr_wdata != 32'd0) chk("wdata_only_at_reset_addr", tmr_address, 2'd0);
      if (prev_valid) chk("valid_not_back_to_back", tmr_valid, 1'b0);
      prev_valid = tmr_valid;
      if (tmr_valid) begin bus_addr.push_back(tmr_address); bus_wd.push_back(tmr_wdata); end
      for (int i = 0; i < N; i++) if (ack[i]) begin ack_id.push_back(i); ack_cyc.push_back(cyc); end

      if (rst_n) begin
         if (!m_act) begin
            if (req_valid != '0) begin
               k = 0;
               while (!req_valid[(m_ptr + k) % N]) k++;
               m_gid = (m_ptr + k) % N;
               m_ptr = (m_gid + 1) % N;
               m_steps.delete();
               if (req_op[m_gid]) m_steps.push_back(2'd0);
               else begin m_steps.push_back(2'd1); m_steps.push_back(2'd2); m_steps.push_back(2'd3); end
               m_act = 1; m_issue = 1; m_done = 0;
            end
         end else if (m_done) begin
            m_act = 0; m_done = 0;
         end else if (m_issue) begin
            m_issue = 0;
         end else if (tmr_ready) begin
            s = m_steps.pop_front();
            if (s == 2'd2) m_ts[63:32] = tmr_rdata;
            if (s == 2'd3) m_ts[31:0]  = tmr_rdata;
            if (m_steps.size() == 0) m_done = 1; else m_issue = 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [3:0] v, input logic [3:0] op, output int t0);
      @(posedge clk); #1;
      req_op = op; req_valid = v; t0 = cyc;
   endtask

   // hold requests until each bit's ack, then drop that bit
   task automatic run_until(input logic [3:0] want, input int budget);
      logic [3:0] got, a;
      int n;
      got = '0; n = 0;
      while ((got & want) != want && n < budget) begin
         @(negedge clk); a = ack; got = got | a; n++;
         @(posedge clk); #1; req_valid = req_valid & ~a;
      end
      chk("acks_within_budget", got & want, want);
   endtask

   task automatic do_reset();
      @(posedge clk); #1; rst_n = 1'b0; req_valid = '0;
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, ab, bb;
      t_ld = 1'b1; t_ld_val = 64'h0000_0001_FFFF_FFF0;
      @(negedge clk);
      chk("reset busy", busy, 1'b0);
      chk("reset ack", ack, 4'b0);
      chk("reset tstamp", tstamp, 64'd0);
      chk("reset tmr_address", tmr_address, 2'd2);
      chk("reset tmr_valid", tmr_valid, 1'b0);
      chk("reset tmr_wdata", tmr_wdata, 32'd0);
      chk("reset grant_id", grant_id, 2'd0);
      @(posedge clk); #1; t_ld = 1'b0; rst_n = 1'b1;

      // 1: single SAMPLE from requester 2, counter frozen
      ab = ack_id.size(); bb = bus_addr.size();
      issue(4'b0100, 4'b0000, t0);
      run_until(4'b0100, 30);
      chk("t1 ack id", ack_id[ab], 2);
      chk("t1 latency", ack_cyc[ab] - t0, 7);
      chk("t1 tstamp", tstamp, 64'h0000_0001_FFFF_FFF0);
      chk("t1 bus count", bus_addr.size() - bb, 3);
      chk("t1 bus order", {bus_addr[bb], bus_addr[bb+1], bus_addr[bb+2]}, {2'd1, 2'd2, 2'd3});

      // 2: RESET then SAMPLE from requester 0, counter running
      t_en = 1'b1;
      ab = ack_id.size(); bb = bus_addr.size();
      issue(4'b0001, 4'b0001, t0);
      run_until(4'b0001, 30);
      chk("t2 reset latency", ack_cyc[ab] - t0, 3);
      chk("t2 reset bus count", bus_addr.size() - bb, 1);
      chk("t2 reset addr", bus_addr[bb], 2'd0);
      chk("t2 reset wdata", bus_wd[bb], 32'd1);
      chk("t2 tstamp kept by reset", tstamp, 64'h0000_0001_FFFF_FFF0);
      issue(4'b0001, 4'b0000, t0);
      run_until(4'b0001, 30);
      chk("t2 tstamp small", tstamp < 64'd16, 1'b1);

      // 3: all four SAMPLE from reset
      do_reset();
      ab = ack_id.size();
      issue(4'b1111, 4'b0000, t0);
      run_until(4'b1111, 60);
      for (int i = 0; i < 4; i++) begin
         chk("t3 ack order", ack_id[ab+i], i);
         chk("t3 ack cycle", ack_cyc[ab+i] - t0, 7 + 8*i);
      end
      // pointer wrapped to 0: requester 0 must beat 3
      ab = ack_id.size();
      issue(4'b1001, 4'b0000, t0);
      run_until(4'b1001, 40);
      chk("t3 ptr back to 0", {ack_id[ab], ack_id[ab+1]}, {32'd0, 32'd3});

      // 4: pointer at 2
      issue(4'b0010, 4'b0000, t0);
      run_until(4'b0010, 30);
      ab = ack_id.size();
      issue(4'b0011, 4'b0000, t0);
      run_until(4'b0011, 40);
      chk("t4 0011 order", {ack_id[ab], ack_id[ab+1]}, {32'd0, 32'd1});
      ab = ack_id.size();
      issue(4'b1010, 4'b0000, t0);
      run_until(4'b1010, 40);
      chk("t4 1010 order", {ack_id[ab], ack_id[ab+1]}, {32'd3, 32'd1});

      // 5: timer wait of 3; request dropped right after grant still completes
      t_wait = 3;
      ab = ack_id.size();
      issue(4'b0100, 4'b0000, t0);
      @(posedge clk); #1; req_valid = '0;
      run_until(4'b0100, 40);
      chk("t5 ack id", ack_id[ab], 2);
      chk("t5 latency", ack_cyc[ab] - t0, 16);
      t_wait = 0;

      // 6: reset in HI_W aborts without ack
      issue(4'b0001, 4'b0000, t0);
      repeat (4) @(posedge clk);
      #1;
      chk("t6 in HI_W busy", busy, 1'b1);
      chk("t6 in HI_W addr", tmr_address, 2'd2);
      ab = ack_id.size();
      rst_n = 1'b0; req_valid = '0;
      #1;
      chk("t6 busy", busy, 1'b0);
      chk("t6 tmr_valid", tmr_valid, 1'b0);
      chk("t6 tmr_wdata", tmr_wdata, 32'd0);
      chk("t6 ack", ack, 4'b0);
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b1;
      chk("t6 no ack for aborted", ack_id.size() - ab, 0);
      issue(4'b1001, 4'b0000, t0);
      run_until(4'b1001, 40);
      chk("t6 served from p=0", {ack_id[ab], ack_id[ab+1]}, {32'd0, 32'd3});

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
